// File: rtl/lfsr_pkg.sv
// Shared types, default polynomial/seed and the single-shift helper for the LFSR PRNG.
// Registers up to 64 bits wide are supported; narrower widths use the low bits.
package lfsr_pkg;

  typedef enum logic {LFSR_WARM, LFSR_RUN} lfsr_fsm_t;

  localparam int unsigned LFSR_MAX_W = 64;
  localparam logic [31:0] LFSR_DEF_TAPS32 = 32'h0820_0005;
  localparam logic [31:0] LFSR_DEF_SEED32 = 32'hDEAD_FACE;

  // One Fibonacci shift: feedback enters at bit width-1, register shifts right.
  function automatic logic [63:0] lfsr_step(input logic [63:0]   val,
                                            input logic [63:0]   taps,
                                            input logic          ent,
                                            input int unsigned   width);
    logic fb;
    fb = (^(val & taps)) ^ ent;
    return (val >> 1) | (64'(fb) << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational advance: STEPS chained single shifts; entropy only feeds the first shift.
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter logic [63:0] TAPS  = 64'(LFSR_DEF_TAPS32),
  parameter int unsigned STEPS = 1
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             ent_i,
  output logic [WIDTH-1:0] val_nxt_o
);

  always_comb begin
    logic [63:0] v;
    v = 64'(val_i);
    for (int unsigned i = 0; i < STEPS; i++) begin
      v = lfsr_step(v, TAPS, (i == 0) ? ent_i : 1'b0, WIDTH);
    end
    val_nxt_o = v[WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR random source with valid/ready output, seed load, warm-up and lockup recovery.
// Define LFSR_PRNG_ENTROPY_EN to add the entropy_in_i port mixed into each advance.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter logic [63:0] TAPS   = 64'(LFSR_DEF_TAPS32),
  parameter logic [63:0] SEED   = 64'(LFSR_DEF_SEED32),
  parameter int unsigned STEPS  = 1,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LFSR_PRNG_ENTROPY_EN
  input  logic             entropy_in_i,
`endif
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_data_i,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [OUT_W-1:0] rnd_data_o,
  output logic [WIDTH-1:0] lfsr_state_o,
  output logic             lockup_o
);

  if (WIDTH < 4 || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be in 4..64");
  end
  if (TAPS[0] == 1'b0) begin : g_bad_taps0
    $error("lfsr_prng: TAPS[0] must be set");
  end
  if ((TAPS >> WIDTH) != 64'd0) begin : g_bad_taps_w
    $error("lfsr_prng: TAPS wider than WIDTH");
  end
  if (SEED[WIDTH-1:0] == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be non-zero");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS out of range");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_prng: OUT_W out of range");
  end

  localparam logic [WIDTH-1:0] SeedW   = SEED[WIDTH-1:0];
  localparam int unsigned      CntW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic             StWarm  = 1'(LFSR_WARM);
  localparam logic             StRun   = 1'(LFSR_RUN);

  logic [WIDTH-1:0] val_q, val_d, val_adv;
  logic             fsm_q, fsm_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             lockup_q, lockup_d;
  logic             ent;

`ifdef LFSR_PRNG_ENTROPY_EN
  assign ent = entropy_in_i;
`else
  assign ent = 1'b0;
`endif

  lfsr_advance #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_advance (
    .val_i     (val_q),
    .ent_i     (ent),
    .val_nxt_o (val_adv)
  );

  // Priority: seed load, then lockup recovery, then warm-up or consumer advance.
  always_comb begin
    val_d    = val_q;
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    lockup_d = 1'b0;
    if (seed_load_i) begin
      val_d = (seed_data_i == '0) ? SeedW : seed_data_i;
      cnt_d = '0;
      fsm_d = (WARMUP == 0) ? StRun : StWarm;
    end else if (val_q == '0) begin
      val_d    = SeedW;
      lockup_d = 1'b1;
      fsm_d    = StWarm;
      cnt_d    = '0;
    end else if (fsm_q == StWarm) begin
      if (WARMUP == 0) begin
        fsm_d = StRun;
      end else begin
        val_d = val_adv;
        if (cnt_q == CntLast) begin
          fsm_d = StRun;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (rnd_ready_i) begin
      val_d = val_adv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q    <= SeedW;
      fsm_q    <= StWarm;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
    end
  end

  assign rnd_valid_o  = (fsm_q == StRun);
  assign rnd_data_o   = val_q[OUT_W-1:0];
  assign lfsr_state_o = val_q;
  assign lockup_o     = lockup_q;

endmodule
